div_reconstruct: RTL

Sequential shift-and-add multiply-accumulate unit that rebuilds a dividend from a quotient, divisor and remainder: P = Q·Y + R. It is the inverse of the non-restoring array divider datapath. It sits downstream of that divider as its consumer, either regenerating the original operand or self-checking divider results. Operands are accepted and the result is returned over valid/ready handshakes. One divisor bit is processed per clock.

---
 rtl/div_recon_pkg.sv | 27 ++
 rtl/div_recon_adder.sv | 23 ++
 rtl/div_reconstruct.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/div_recon_pkg.sv
// div_recon_pkg: shared types and width helpers for the dividend reconstruction unit.
// The state enum, default operand widths and the result-width derivation are kept here
// so that the top level and the bench agree on them.
package div_recon_pkg;

  localparam int WQ_DEF = 3;
  localparam int WY_DEF = 2;
  localparam int WR_DEF = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Result width: wide enough for Q*Y + R, so the top carry can never be lost.
  function automatic int recon_wp(input int wq, input int wy, input int wr);
    int prod_w;
    prod_w = wq + wy;
    if (wr > prod_w) begin
      return wr + 1;
    end else begin
      return prod_w + 1;
    end
  endfunction

endpackage

// File: rtl/div_recon_adder.sv
// div_recon_adder: W-bit ripple-carry adder built from full-adder cells.
// Carry-in is zero. The most significant cell produces only a sum bit because the
// caller sizes W so that the final carry is always zero.
module div_recon_adder #(
  parameter int W = 6
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_sum
);

  logic [W-1:0] w_c;

  assign w_c[0] = 1'b0;

  for (genvar g = 0; g < W; g++) begin : g_fa
    assign o_sum[g] = i_a[g] ^ i_b[g] ^ w_c[g];
    if (g < W - 1) begin : g_carry
      assign w_c[g+1] = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
    end
  end

endmodule

// File: rtl/div_reconstruct.sv
// div_reconstruct: sequential shift-and-add unit computing P = Q*Y + R, one divisor bit
// per clock, with valid/ready handshakes on both sides.
// Optional feature macro: DIV_RECON_CHECK_EN adds in_x (expected dividend) and out_err
// (registered P != in_x flag). Datapath and timing are identical in both builds.
module div_reconstruct
  import div_recon_pkg::*;
#(
  parameter  int WQ = WQ_DEF,
  parameter  int WY = WY_DEF,
  parameter  int WR = WR_DEF,
  localparam int WP = recon_wp(WQ, WY, WR)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WQ-1:0] in_q,
  input  logic [WY-1:0] in_y,
  input  logic [WR-1:0] in_r,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WP-1:0] out_p
`ifdef DIV_RECON_CHECK_EN
  ,
  input  logic [WP-1:0] in_x,
  output logic          out_err
`endif
);

  localparam int CW = $clog2(WY + 1);

  state_e        r_state;
  state_e        w_state_nxt;

  logic [WP-1:0] r_m;
  logic [WY-1:0] r_s;
  logic [WP-1:0] r_a;
  logic [CW-1:0] r_cnt;
  logic          r_in_ready;
  logic          r_out_valid;
  logic [WP-1:0] r_out_p;

  logic          w_last;
  logic          w_load;
  logic          w_iter;
  logic          w_finish;
  logic          w_consume;
  logic [WP-1:0] w_addend;
  logic [WP-1:0] w_sum;

  // Last iteration is the one whose counter value is WY-1.
  assign w_last = (r_cnt == CW'(WY - 1));

  // Gate the multiplicand with the current divisor bit; the adder itself is unconditional.
  assign w_addend = r_s[0] ? r_m : {WP{1'b0}};

  div_recon_adder #(
    .W (WP)
  ) u_adder (
    .i_a   (r_a),
    .i_b   (w_addend),
    .o_sum (w_sum)
  );

  // State register: reset always returns to IDLE, abandoning any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic for the IDLE -> RUN -> DONE -> IDLE cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (r_in_ready && in_valid) begin
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RUN: begin
        if (w_last) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = DONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Per-state control strobes driving the datapath and output registers.
  always_comb begin
    w_load    = 1'b0;
    w_iter    = 1'b0;
    w_finish  = 1'b0;
    w_consume = 1'b0;
    case (r_state)
      IDLE: begin
        w_load = r_in_ready & in_valid;
      end
      RUN: begin
        w_iter   = 1'b1;
        w_finish = w_last;
      end
      DONE: begin
        w_consume = out_ready;
      end
      default: begin
        w_load = 1'b0;
      end
    endcase
  end

  // in_ready is registered from the next state so it is high exactly while in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_ready <= 1'b1;
    end else begin
      r_in_ready <= (w_state_nxt == IDLE);
    end
  end

  // Iteration datapath: load operands on accept, then shift-and-add once per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_m   <= {WP{1'b0}};
      r_s   <= {WY{1'b0}};
      r_a   <= {WP{1'b0}};
      r_cnt <= {CW{1'b0}};
    end else if (w_load) begin
      r_m   <= WP'(in_q);
      r_s   <= in_y;
      r_a   <= WP'(in_r);
      r_cnt <= {CW{1'b0}};
    end else if (w_iter) begin
      r_a   <= w_sum;
      r_m   <= r_m << 1;
      r_s   <= r_s >> 1;
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Result registers: capture the final accumulator sum on the last iteration, hold in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_p     <= {WP{1'b0}};
    end else if (w_finish) begin
      r_out_valid <= 1'b1;
      r_out_p     <= w_sum;
    end else if (w_consume) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_p     = r_out_p;

`ifdef DIV_RECON_CHECK_EN
  logic [WP-1:0] r_x;
  logic          r_out_err;

  // Expected-dividend capture at accept time.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x <= {WP{1'b0}};
    end else if (w_load) begin
      r_x <= in_x;
    end
  end

  // Error flag is registered alongside out_p and cleared when the result is consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_err <= 1'b0;
    end else if (w_finish) begin
      r_out_err <= (w_sum != r_x);
    end else if (w_consume) begin
      r_out_err <= 1'b0;
    end
  end

  assign out_err = r_out_err;
`endif

endmodule
